filter2d_host: RTL
==================

FILTER2D_HOST -- requirements
Module: filter2d_host

Interface
REQ-001 Parameter WIDTH, default 256, image side in pixels; frame is WIDTH*WIDTH 8-bit pixels.
REQ-002 Parameter ADDR_W, default 17, SRAM address width; input region 0..WIDTH*WIDTH-1, result region WIDTH*WIDTH..2*WIDTH*WIDTH-1.
REQ-003 clk  input  1  clock, all logic rising-edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 go  input  1  one-cycle frame request, honoured in IDLE only.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle pulse when the last result pixel is accepted downstream.
REQ-008 cfg_we / cfg_idx[3:0] / cfg_data[7:0]  input  1/4/8  kernel shadow write port.
REQ-009 in_valid / in_ready / in_data[7:0]  input/output/input  1/1/8  raster-order pixel input stream.
REQ-010 out_valid / out_ready / out_data[7:0]  output/input/output  1/1/8  raster-order result output stream.
REQ-011 sram_own  output  1  high when this block drives the SRAM; top level muxes SRAM to the filter when low.
REQ-012 cs / we / addr[ADDR_W-1:0] / din[7:0] / dout[7:0]  out/out/out/out/in  SRAM port; dout valid the cycle after a read cs.
REQ-013 start  output  1  one-cycle filter start strobe; finish  input  1  filter completion strobe.
REQ-014 h_write / h_idx[3:0] / h_data[7:0]  output  1/4/8  filter kernel load port.

Function
REQ-015 States IDLE, LOAD, KERN, START, RUN, DRAIN; IDLE->LOAD on go.
REQ-016 LOAD: in_ready=1; each in_valid&in_ready writes in_data to addr=pixel count (cs=we=1, same cycle); after write WIDTH*WIDTH-1 -> KERN.
REQ-017 KERN: exactly 9 cycles, h_write=1, h_idx=0..8, h_data=shadow[h_idx]; then -> START.
REQ-018 START: start=1 for one cycle, sram_own=0; -> RUN.
REQ-019 RUN: sram_own=0, cs/we=0; stays until finish=1; -> DRAIN next cycle.
REQ-020 finish outside RUN ignored; go outside IDLE ignored.
REQ-021 sram_own=1 in IDLE, LOAD, KERN, DRAIN; 0 in START, RUN.
REQ-022 DRAIN: reads result addresses WIDTH*WIDTH+k, k=0..WIDTH*WIDTH-1, in order, cs=1,we=0.
REQ-023 DRAIN output buffer: 2-entry FIFO; read issued only when occupancy + reads in flight < 2; no pixel lost or duplicated under any out_ready pattern.
REQ-024 out_valid = FIFO non-empty; out_data = FIFO head; pop on out_valid&out_ready.
REQ-025 With out_ready held 1, DRAIN sustains one pixel per cycle after a 2-cycle initial latency (read issue -> dout -> FIFO -> out_valid).
REQ-026 Last result pop: done=1 that cycle, state -> IDLE next cycle.
REQ-027 Shadow kernel: 9 x 8-bit, cfg_we writes shadow[cfg_idx] in IDLE only; cfg_idx>8 or non-IDLE writes ignored.
REQ-028 Pixel/address counters WIDTH*WIDTH-range, no wrap except reset to 0 on state entry.
REQ-029 din=in_data during LOAD; outputs start, h_write, done, cs, we zero in all states not listed above.

Reset
REQ-030 On reset_n low: state IDLE, all counters 0, FIFO empty, in-flight 0; busy/done/start/h_write/cs/we/out_valid/in_ready=0, sram_own=1, addr/din/h_idx/h_data=0.
REQ-031 Shadow reset values idx0..8: 08,10,08,10,20,10,08,10,08 (hex).
REQ-032 Reset mid-frame aborts immediately; no start/h_write emitted after deassert until a new go.

Structure
REQ-033 Shared package holds state encoding, kernel size constant 9, default kernel table.
REQ-034 One sub-module: filter2d_host_fifo (2-entry, 8-bit, valid/ready) used in DRAIN.

Verification
REQ-035 WIDTH=4, go, 16 pixels 0..15 with in_valid always 1 -> 16 writes addr 0..15, then 9 h_write cycles with default kernel, one start pulse.
REQ-036 cfg_we idx4=0x40 in IDLE, then frame -> h_idx4 carries 0x40; cfg_we during RUN -> no shadow change.
REQ-037 Filter model answers finish; result region preset to 100..115, out_ready=1 -> out_data 100..115 consecutive cycles, done with 115.
REQ-038 out_ready toggling random 30% -> output sequence 100..115 exact, never more than 2 reads outstanding+buffered.
REQ-039 Spurious finish in LOAD and go in RUN -> no state change.
REQ-040 reset_n low during DRAIN k=7 -> all outputs to reset values same cycle; next go restarts LOAD at addr 0.

Source files
------------

// File: rtl/filter2d_host_pkg.sv
// Shared definitions for the filter2d host controller.
//   state_t        : controller state encoding
//   KERN_SIZE      : number of 3x3 kernel taps
//   default_kernel : reset value of each kernel tap (idx 0..8)
package filter2d_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KERN,
    ST_START,
    ST_RUN,
    ST_DRAIN
  } state_t;

  localparam int unsigned KERN_SIZE = 9;

  // Normalised 3x3 smoothing kernel: corners 08, edges 10, centre 20.
  function automatic logic [7:0] default_kernel(input int unsigned idx);
    case (idx)
      0, 2, 6, 8: default_kernel = 8'h08;
      1, 3, 5, 7: default_kernel = 8'h10;
      4:          default_kernel = 8'h20;
      default:    default_kernel = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/filter2d_host_fifo.sv
// Two-entry 8-bit FIFO buffering SRAM read data during result drain.
//   clk, reset_n : clock, asynchronous active-low reset
//   in_valid     : push in_data (caller guarantees space via count)
//   in_data      : pushed byte
//   out_valid    : FIFO non-empty
//   out_ready    : pop head when out_valid
//   out_data     : FIFO head
//   count        : current occupancy 0..2
module filter2d_host_fifo (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [1:0] count
);

  logic [7:0] mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       push;
  logic       pop;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign push      = in_valid && (count_q != 2'd2);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/filter2d_host.sv
// Host-side sequencer for a 2D image filter sharing one SRAM.
// Loads a WIDTH x WIDTH frame into SRAM, pushes the 3x3 kernel to the
// filter, starts it, waits for completion, then streams the result region
// back out.
//   clk, reset_n                   : clock, asynchronous active-low reset
//   go / busy / done               : frame request, activity, completion pulse
//   cfg_we / cfg_idx / cfg_data    : kernel shadow write (IDLE only)
//   in_valid / in_ready / in_data  : raster pixel input stream
//   out_valid / out_ready/ out_data: raster result output stream
//   sram_own                       : this block owns the SRAM when high
//   cs / we / addr / din / dout    : SRAM port (dout one cycle after read)
//   start / finish                 : filter start strobe / completion strobe
//   h_write / h_idx / h_data       : filter kernel load port
module filter2d_host
  import filter2d_host_pkg::*;
#(
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  output logic              busy,
  output logic              done,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_idx,
  input  logic [7:0]        cfg_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              sram_own,
  output logic              cs,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        din,
  input  logic [7:0]        dout,
  output logic              start,
  input  logic              finish,
  output logic              h_write,
  output logic [3:0]        h_idx,
  output logic [7:0]        h_data
);

  localparam int unsigned       NPIX     = WIDTH * WIDTH;
  localparam int unsigned       CNT_W    = $clog2(NPIX + 1);
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(NPIX - 1);
  localparam logic [CNT_W-1:0]  ALL      = CNT_W'(NPIX);
  localparam logic [ADDR_W-1:0] RES_BASE = ADDR_W'(NPIX);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pix_cnt_q, rd_cnt_q, pop_cnt_q;
  logic [3:0]       kidx_q;
  logic             inflight_q;
  logic [7:0]       shadow_q [KERN_SIZE];

  logic             px_wr;
  logic             rd_issue;
  logic             pop;
  logic [2:0]       pending;
  logic             fifo_out_valid;
  logic [7:0]       fifo_out_data;
  logic [1:0]       fifo_count;

  filter2d_host_fifo u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (inflight_q),
    .in_data   (dout),
    .out_valid (fifo_out_valid),
    .out_ready (out_ready),
    .out_data  (fifo_out_data),
    .count     (fifo_count)
  );

  assign out_valid = fifo_out_valid;
  assign out_data  = fifo_out_data;
  assign pop       = fifo_out_valid && out_ready;

  // Slots committed after this cycle's pop. Counting the same-cycle pop as
  // freed space is what lets the drain reach one pixel per cycle while still
  // never holding more than two bytes buffered or in flight.
  assign pending = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt_q  <= '0;
      rd_cnt_q   <= '0;
      pop_cnt_q  <= '0;
      kidx_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_issue;
      if (state_d != state_q) begin
        pix_cnt_q <= '0;
        rd_cnt_q  <= '0;
        pop_cnt_q <= '0;
        kidx_q    <= '0;
      end else begin
        if (px_wr)              pix_cnt_q <= pix_cnt_q + CNT_W'(1);
        if (rd_issue)           rd_cnt_q  <= rd_cnt_q + CNT_W'(1);
        if (pop)                pop_cnt_q <= pop_cnt_q + CNT_W'(1);
        if (state_q == ST_KERN) kidx_q    <= kidx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < KERN_SIZE; i++) begin
        shadow_q[i] <= default_kernel(i);
      end
    end else if (cfg_we && (state_q == ST_IDLE) && (cfg_idx < 4'(KERN_SIZE))) begin
      shadow_q[cfg_idx] <= cfg_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b1;
    done     = 1'b0;
    in_ready = 1'b0;
    sram_own = 1'b1;
    cs       = 1'b0;
    we       = 1'b0;
    addr     = '0;
    din      = '0;
    start    = 1'b0;
    h_write  = 1'b0;
    h_idx    = '0;
    h_data   = '0;
    px_wr    = 1'b0;
    rd_issue = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (go) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        din      = in_data;
        addr     = ADDR_W'(pix_cnt_q);
        px_wr    = in_valid;
        cs       = in_valid;
        we       = in_valid;
        if (in_valid && (pix_cnt_q == LAST)) state_d = ST_KERN;
      end
      ST_KERN: begin
        h_write = 1'b1;
        h_idx   = kidx_q;
        h_data  = shadow_q[kidx_q];
        if (kidx_q == 4'(KERN_SIZE - 1)) state_d = ST_START;
      end
      ST_START: begin
        start    = 1'b1;
        sram_own = 1'b0;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        sram_own = 1'b0;
        if (finish) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        rd_issue = (rd_cnt_q != ALL) && (pending < 3'd2);
        cs       = rd_issue;
        addr     = RES_BASE + ADDR_W'(rd_cnt_q);
        if (pop && (pop_cnt_q == LAST)) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
